// File: rtl/ccc_pkg.sv
// Shared types and default constants for the CCC clock-enable generator.
// Imported by the top and the per-channel divider.
package ccc_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int DIV_W_DEF       = 8;
  localparam int LOCK_FILT_DEF   = 16;
  localparam int RST_STAGGER_DEF = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/ccc_clken_div.sv
// Per-channel divider: one-cycle enable every div+1 cycles while released.
// The divide value is captured into the counter at reload time.
module ccc_clken_div
  import ccc_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             clken
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // Writes land in div_q; the running period lives in cnt_q only,
  // so a mid-period write never truncates or extends it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load) div_q <= val;
      if (!rst_n)
        cnt_q <= '0;
      else if (cnt_q == '0)
        cnt_q <= div_q;
      else
        cnt_q <= cnt_q - 1'b1;
    end
  end

  assign clken = rst_n && (cnt_q == '0);

endmodule

// File: rtl/ccc_clken_gen.sv
// Lock-qualified, staggered reset release and clock-enable generation
// for NUM_CH fabric domains running off a single CCC output clock.
module ccc_clken_gen
  import ccc_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int LOCK_FILT   = LOCK_FILT_DEF,
  parameter int RST_STAGGER = RST_STAGGER_DEF
) (
  input  logic              CLK0,
  input  logic              ARST,
  input  logic              LOCK,
  input  logic              DIV_LOAD,
  input  logic [2:0]        DIV_CH,
  input  logic [DIV_W-1:0]  DIV_VAL,
  output logic [NUM_CH-1:0] CLKEN,
  output logic [NUM_CH-1:0] RST_N_OUT,
  output logic              LOCKED,
  output logic [7:0]        LOST_CNT
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int SW = $clog2(RST_STAGGER * NUM_CH + 1);

  logic lock_s1, lock_s;

  state_e            state_q, state_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic [SW-1:0]     stag_q, stag_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              locked_q, locked_d;
  logic [7:0]        lost_q, lost_d;

  always_ff @(posedge CLK0 or posedge ARST) begin
    if (ARST) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_s1 <= LOCK;
      lock_s  <= lock_s1;
    end
  end

  always_ff @(posedge CLK0 or posedge ARST) begin
    if (ARST) begin
      state_q  <= WAIT_LOCK;
      filt_q   <= '0;
      stag_q   <= '0;
      rst_n_q  <= '0;
      locked_q <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      stag_q   <= stag_d;
      rst_n_q  <= rst_n_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    filt_d   = '0;
    stag_d   = '0;
    rst_n_d  = rst_n_q;
    locked_d = locked_q;
    lost_d   = lost_q;
    unique case (state_q)
      WAIT_LOCK: begin
        rst_n_d  = '0;
        locked_d = 1'b0;
        if (lock_s) begin
          if (filt_q == FW'(LOCK_FILT - 1))
            state_d = RELEASE;
          else
            filt_d = filt_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          rst_n_d  = '0;
          locked_d = 1'b0;
          if (lost_q != 8'hFF) lost_d = lost_q + 1'b1;
        end else if (state_q == RELEASE) begin
          stag_d = stag_q + 1'b1;
          for (int i = 0; i < NUM_CH; i++)
            if (stag_q == SW'(RST_STAGGER * (i + 1)))
              rst_n_d[i] = 1'b1;
          if (stag_q == SW'(RST_STAGGER * NUM_CH)) begin
            state_d  = RUN;
            locked_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ccc_clken_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk   (CLK0),
      .arst  (ARST),
      .rst_n (rst_n_q[g]),
      .load  (DIV_LOAD && (DIV_CH == 3'(g))),
      .val   (DIV_VAL),
      .clken (CLKEN[g])
    );
  end

  assign RST_N_OUT = rst_n_q;
  assign LOCKED    = locked_q;
  assign LOST_CNT  = lost_q;

endmodule
